// File: rtl/db_arb.sv
// db_arb: round-robin arbiter sharing one lookup-engine request port between
// two requesters; tracks in-flight lookups in issue order and steers results back.

module db_arb #(
  parameter int KEY_SIZE  = 96,
  parameter int FLAG_SIZE = 4,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [KEY_SIZE-1:0]  a_key,
  input  logic [FLAG_SIZE-1:0] a_flag,
  output logic                 a_rsp_valid,
  output logic [FLAG_SIZE-1:0] a_rsp_flag,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [KEY_SIZE-1:0]  b_key,
  input  logic [FLAG_SIZE-1:0] b_flag,
  output logic                 b_rsp_valid,
  output logic [FLAG_SIZE-1:0] b_rsp_flag,
  output logic                 db_valid,
  output logic [KEY_SIZE-1:0]  db_key,
  output logic [FLAG_SIZE-1:0] db_flag,
  input  logic                 db_rsp_valid,
  input  logic [FLAG_SIZE-1:0] db_rsp_flag,
  output logic                 err_timeout,
  output logic                 err_orphan
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("db_arb: DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("db_arb: TIMEOUT must be at least 1");
  end

  // Tracking state
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [WW-1:0]        wd_q, wd_d;
  port_e                last_q, last_d;
  port_e                tag_q [DEPTH];

  // Registered outputs
  logic                 db_valid_q, db_valid_d;
  logic [KEY_SIZE-1:0]  db_key_q, db_key_d;
  logic [FLAG_SIZE-1:0] db_flag_q, db_flag_d;
  logic                 a_rsp_valid_q, a_rsp_valid_d;
  logic [FLAG_SIZE-1:0] a_rsp_flag_q, a_rsp_flag_d;
  logic                 b_rsp_valid_q, b_rsp_valid_d;
  logic [FLAG_SIZE-1:0] b_rsp_flag_q, b_rsp_flag_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 err_orphan_q, err_orphan_d;

  logic  full, empty, pop, flush, grant_ok, push;
  port_e push_port, pop_port;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign pop   = db_rsp_valid && !empty;
  assign flush = !empty && !pop && (wd_q == WD_LAST);

  // Grants look only at registered occupancy, never at a same-cycle pop.
  assign grant_ok  = rst && !full && !flush;
  assign a_ready   = grant_ok && a_valid && (!b_valid || (last_q == PORT_B));
  assign b_ready   = grant_ok && b_valid && (!a_valid || (last_q == PORT_A));
  assign push      = a_ready || b_ready;
  assign push_port = b_ready ? PORT_B : PORT_A;
  assign pop_port  = tag_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    wd_d          = wd_q;
    last_d        = last_q;
    db_valid_d    = push;
    db_key_d      = db_key_q;
    db_flag_d     = db_flag_q;
    a_rsp_valid_d = pop && (pop_port == PORT_A);
    a_rsp_flag_d  = a_rsp_flag_q;
    b_rsp_valid_d = pop && (pop_port == PORT_B);
    b_rsp_flag_d  = b_rsp_flag_q;
    err_timeout_d = flush;
    err_orphan_d  = db_rsp_valid && empty;

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      wd_d     = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      wd_d = (empty || pop) ? '0 : wd_q + WW'(1);
    end

    if (push) begin
      last_d    = push_port;
      db_key_d  = (push_port == PORT_B) ? b_key  : a_key;
      db_flag_d = (push_port == PORT_B) ? b_flag : a_flag;
    end
    if (a_rsp_valid_d) a_rsp_flag_d = db_rsp_flag;
    if (b_rsp_valid_d) b_rsp_flag_d = db_rsp_flag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wd_q          <= '0;
      last_q        <= PORT_A;
      db_valid_q    <= 1'b0;
      db_key_q      <= '0;
      db_flag_q     <= '0;
      a_rsp_valid_q <= 1'b0;
      a_rsp_flag_q  <= '0;
      b_rsp_valid_q <= 1'b0;
      b_rsp_flag_q  <= '0;
      err_timeout_q <= 1'b0;
      err_orphan_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wd_q          <= wd_d;
      last_q        <= last_d;
      db_valid_q    <= db_valid_d;
      db_key_q      <= db_key_d;
      db_flag_q     <= db_flag_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      a_rsp_flag_q  <= a_rsp_flag_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      b_rsp_flag_q  <= b_rsp_flag_d;
      err_timeout_q <= err_timeout_d;
      err_orphan_q  <= err_orphan_d;
    end
  end

  // NOTE: the tag storage is left unreset; count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= push_port;
  end

  assign db_valid    = db_valid_q;
  assign db_key      = db_key_q;
  assign db_flag     = db_flag_q;
  assign a_rsp_valid = a_rsp_valid_q;
  assign a_rsp_flag  = a_rsp_flag_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign b_rsp_flag  = b_rsp_flag_q;
  assign err_timeout = err_timeout_q;
  assign err_orphan  = err_orphan_q;

  a_one_ready: assert property (@(posedge clk) disable iff (!rst) !(a_ready && b_ready));
  a_count_bound: assert property (@(posedge clk) disable iff (!rst) count_q <= FULL_CNT);
  a_no_ready_full: assert property (@(posedge clk) disable iff (!rst) full |-> !push);

endmodule

// File: tb/tb_db_arb.sv
// tb_db_arb: directed scenarios plus randomized traffic for db_arb, checked
// against a queue-based model of outstanding lookups.

module tb_db_arb;

  localparam int KS      = 96;
  localparam int FS      = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0, db_rsp_valid = 1'b0;
  logic [KS-1:0] a_key = '0, b_key = '0;
  logic [FS-1:0] a_flag = '0, b_flag = '0, db_rsp_flag = '0;
  logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid, db_valid;
  logic          err_timeout, err_orphan;
  logic [FS-1:0] a_rsp_flag, b_rsp_flag, db_flag;
  logic [KS-1:0] db_key;

  always #5 clk = ~clk;

  db_arb #(.KEY_SIZE(KS), .FLAG_SIZE(FS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_key(a_key), .a_flag(a_flag),
    .a_rsp_valid(a_rsp_valid), .a_rsp_flag(a_rsp_flag),
    .b_valid(b_valid), .b_ready(b_ready), .b_key(b_key), .b_flag(b_flag),
    .b_rsp_valid(b_rsp_valid), .b_rsp_flag(b_rsp_flag),
    .db_valid(db_valid), .db_key(db_key), .db_flag(db_flag),
    .db_rsp_valid(db_rsp_valid), .db_rsp_flag(db_rsp_flag),
    .err_timeout(err_timeout), .err_orphan(err_orphan)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of issuing ports (0=A, 1=B), age since last progress.
  int            m_q[$];
  bit            m_last;
  int            m_age;
  logic          obs_a_ready, obs_b_ready;
  logic          m_a_ready, m_b_ready, m_db_valid, m_a_rsp_v, m_b_rsp_v, m_err_to, m_err_or;
  logic [KS-1:0] m_db_key;
  logic [FS-1:0] m_db_flag, m_rsp_f;

  task automatic m_reset();
    m_q.delete();
    m_last = 1'b0;
    m_age  = 0;
  endtask

  // One clock: drive inputs, capture ready, clock, advance the model.
  task automatic cyc(input bit av, input logic [KS-1:0] ak, input logic [FS-1:0] af,
                     input bit bv, input logic [KS-1:0] bk, input logic [FS-1:0] bf,
                     input bit rv, input logic [FS-1:0] rf);
    int sz, head;
    bit full, pop, flush, ga, gb;
    a_valid = av; a_key = ak; a_flag = af;
    b_valid = bv; b_key = bk; b_flag = bf;
    db_rsp_valid = rv; db_rsp_flag = rf;
    #1;
    obs_a_ready = a_ready;
    obs_b_ready = b_ready;
    sz    = m_q.size();
    full  = (sz == DEPTH);
    pop   = rv && (sz > 0);
    flush = (sz > 0) && !pop && (m_age == TIMEOUT - 1);
    ga    = av && !full && !flush && (!bv || m_last);
    gb    = bv && !full && !flush && (!av || !m_last);
    head  = (sz > 0) ? m_q[0] : 0;
    m_a_ready = ga;
    m_b_ready = gb;
    @(posedge clk);
    #1;
    m_db_valid = ga || gb;
    if (ga) begin m_db_key = ak; m_db_flag = af; end
    if (gb) begin m_db_key = bk; m_db_flag = bf; end
    m_a_rsp_v = pop && (head == 0);
    m_b_rsp_v = pop && (head == 1);
    if (pop) m_rsp_f = rf;
    m_err_or = rv && (sz == 0);
    m_err_to = flush;
    if (flush) begin
      m_q.delete();
      m_age = 0;
    end else begin
      if (sz == 0 || pop) m_age = 0;
      else m_age++;
      if (pop) void'(m_q.pop_front());
      if (ga) m_q.push_back(0);
      if (gb) m_q.push_back(1);
    end
    if (ga) m_last = 1'b0;
    if (gb) m_last = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, '0, 0, '0);
  endtask

  function automatic logic [KS+3*FS+7:0] all_outs();
    return {db_valid, db_key, db_flag, a_rsp_valid, a_rsp_flag, b_rsp_valid, b_rsp_flag,
            err_timeout, err_orphan, a_ready, b_ready};
  endfunction

  task automatic test_reset();
    a_valid = 1'b1; b_valid = 1'b1;
    #1 rst = 1'b0;
    #2;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", all_outs());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_held got %h want 0", all_outs());
    end
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b1;
    m_reset();
  endtask

  task automatic test_single_a();
    logic [KS-1:0] k;
    k = 96'h0A000001_0A000002_1F900000;
    cyc(1, k, 4'h1, 0, '0, '0, 0, '0);
    checks++;
    if (obs_a_ready !== 1'b1 || obs_b_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready got a=%b b=%b want a=1 b=0", obs_a_ready, obs_b_ready);
    end
    checks++;
    if (db_valid !== 1'b1 || db_key !== k || db_flag !== 4'h1) begin
      errors++; $display("FAIL single_issue got v=%b key=%h flag=%h want v=1 key=%h flag=1", db_valid, db_key, db_flag, k);
    end
    idle(1);
    checks++;
    if (db_valid !== 1'b0) begin
      errors++; $display("FAIL single_db_pulse got %b want 0", db_valid);
    end
    idle(1);
    cyc(0, '0, '0, 0, '0, '0, 1, 4'h3);
    checks++;
    if (a_rsp_valid !== 1'b1 || a_rsp_flag !== 4'h3 || b_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_rsp got a=%b flag=%h b=%b want a=1 flag=3 b=0", a_rsp_valid, a_rsp_flag, b_rsp_valid);
    end
    idle(1);
    checks++;
    if (a_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_rsp_pulse got %b want 0", a_rsp_valid);
    end
  endtask

  task automatic test_alternate();
    logic [KS-1:0] ka, kb;
    logic [FS-1:0] rf;
    bit            want_b, rsp_b;
    for (int k = 0; k < 7; k++) begin
      ka = {32'hAAAA0000, 32'h0, 32'(k)};
      kb = {32'hBBBB0000, 32'h0, 32'(k)};
      rf = 4'(k + 2);
      cyc(k < 6, ka, 4'h4, k < 6, kb, 4'h8, k > 0, rf);
      want_b = (k % 2 == 0);
      if (k < 6) begin
        checks++;
        if (obs_b_ready !== want_b || obs_a_ready !== !want_b) begin
          errors++; $display("FAIL alt_grant k=%0d got a=%b b=%b want b=%b", k, obs_a_ready, obs_b_ready, want_b);
        end
        checks++;
        if (db_valid !== 1'b1 || db_key !== (want_b ? kb : ka)) begin
          errors++; $display("FAIL alt_issue k=%0d got v=%b key=%h want key=%h", k, db_valid, db_key, want_b ? kb : ka);
        end
      end
      if (k > 0) begin
        rsp_b = ((k - 1) % 2 == 0);
        checks++;
        if (b_rsp_valid !== rsp_b || a_rsp_valid !== !rsp_b ||
            (rsp_b ? b_rsp_flag : a_rsp_flag) !== rf) begin
          errors++; $display("FAIL alt_rsp k=%0d got a=%b b=%b want b=%b flag=%h", k, a_rsp_valid, b_rsp_valid, rsp_b, rf);
        end
      end
      checks++;
      if (err_timeout !== 1'b0 || err_orphan !== 1'b0) begin
        errors++; $display("FAIL alt_err k=%0d got to=%b or=%b want 0 0", k, err_timeout, err_orphan);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [KS-1:0] keys[5];
    bit            want;
    for (int i = 0; i < 5; i++) keys[i] = {32'hC0DE0000, 32'h0, 32'(i)};
    for (int i = 0; i < 5; i++) begin
      cyc(1, keys[i], 4'h2, 0, '0, '0, 0, '0);
      want = (i < 4);
      checks++;
      if (obs_a_ready !== want) begin
        errors++; $display("FAIL b2b_ready i=%0d got %b want %b", i, obs_a_ready, want);
      end
      if (want) begin
        checks++;
        if (db_key !== keys[i]) begin
          errors++; $display("FAIL b2b_key i=%0d got %h want %h", i, db_key, keys[i]);
        end
      end
    end
    cyc(1, keys[4], 4'h2, 0, '0, '0, 1, 4'h9);
    checks++;
    if (obs_a_ready !== 1'b0 || a_rsp_valid !== 1'b1 || a_rsp_flag !== 4'h9) begin
      errors++; $display("FAIL b2b_pop_blocked got ready=%b rsp=%b flag=%h want 0 1 9", obs_a_ready, a_rsp_valid, a_rsp_flag);
    end
    cyc(1, keys[4], 4'h2, 0, '0, '0, 0, '0);
    checks++;
    if (obs_a_ready !== 1'b1 || db_key !== keys[4]) begin
      errors++; $display("FAIL b2b_fifth got ready=%b key=%h want 1 %h", obs_a_ready, db_key, keys[4]);
    end
    cyc(1, keys[4], 4'h2, 0, '0, '0, 0, '0);
    checks++;
    if (obs_a_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_full_again got %b want 0", obs_a_ready);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, '0, 0, '0, '0, 1, 4'(i + 10));
      checks++;
      if (a_rsp_valid !== 1'b1 || a_rsp_flag !== 4'(i + 10) || err_orphan !== 1'b0) begin
        errors++; $display("FAIL b2b_drain i=%0d got v=%b flag=%h or=%b", i, a_rsp_valid, a_rsp_flag, err_orphan);
      end
    end
  endtask

  task automatic test_orphan();
    cyc(0, '0, '0, 0, '0, '0, 1, 4'h5);
    checks++;
    if (err_orphan !== 1'b1 || a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0 || db_valid !== 1'b0) begin
      errors++; $display("FAIL orphan_pulse got or=%b a=%b b=%b db=%b want 1 0 0 0", err_orphan, a_rsp_valid, b_rsp_valid, db_valid);
    end
    idle(1);
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++; $display("FAIL orphan_width got %b want 0", err_orphan);
    end
    cyc(1, 96'h1234, 4'h1, 0, '0, '0, 0, '0);
    cyc(0, '0, '0, 0, '0, '0, 1, 4'h6);
    checks++;
    if (a_rsp_valid !== 1'b1 || a_rsp_flag !== 4'h6 || err_orphan !== 1'b0) begin
      errors++; $display("FAIL orphan_after got v=%b flag=%h or=%b want 1 6 0", a_rsp_valid, a_rsp_flag, err_orphan);
    end
  endtask

  task automatic test_timeout();
    cyc(0, '0, '0, 1, 96'hB1, 4'h1, 0, '0);
    cyc(0, '0, '0, 1, 96'hB2, 4'h1, 0, '0);
    checks++;
    if (obs_b_ready !== 1'b1) begin
      errors++; $display("FAIL to_issue got %b want 1", obs_b_ready);
    end
    for (int k = 3; k <= 8; k++) begin
      cyc(0, '0, '0, 0, '0, '0, 0, '0);
      checks++;
      if (err_timeout !== 1'b0) begin
        errors++; $display("FAIL to_early cyc=%0d got %b want 0", k, err_timeout);
      end
    end
    cyc(0, '0, '0, 1, 96'hB3, 4'h1, 0, '0);
    checks++;
    if (obs_b_ready !== 1'b0 || err_timeout !== 1'b1) begin
      errors++; $display("FAIL to_flush got ready=%b to=%b want 0 1", obs_b_ready, err_timeout);
    end
    cyc(0, '0, '0, 0, '0, '0, 1, 4'h7);
    checks++;
    if (err_timeout !== 1'b0 || err_orphan !== 1'b1 || b_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL to_late got to=%b or=%b rsp=%b want 0 1 0", err_timeout, err_orphan, b_rsp_valid);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) cyc(1, 96'(i + 100), 4'h3, 0, '0, '0, 0, '0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL mid_reset_async got %h want 0", all_outs());
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_reset();
    cyc(0, '0, '0, 0, '0, '0, 1, 4'h2);
    checks++;
    if (err_orphan !== 1'b1 || a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_stale got or=%b a=%b b=%b want 1 0 0", err_orphan, a_rsp_valid, b_rsp_valid);
    end
    cyc(1, 96'hAA, 4'h1, 1, 96'hBB, 4'h2, 0, '0);
    checks++;
    if (obs_b_ready !== 1'b1 || obs_a_ready !== 1'b0 || db_key !== 96'hBB) begin
      errors++; $display("FAIL mid_tie got a=%b b=%b key=%h want 0 1 bb", obs_a_ready, obs_b_ready, db_key);
    end
  endtask

  task automatic test_random();
    bit            av, bv, rv;
    logic [KS-1:0] ak, bk;
    for (int i = 0; i < 600; i++) begin
      av = ($urandom_range(99) < 60);
      bv = ($urandom_range(99) < 50);
      rv = ($urandom_range(99) < ((i < 300) ? 55 : 8));
      ak = {$urandom, $urandom, $urandom};
      bk = {$urandom, $urandom, $urandom};
      cyc(av, ak, 4'($urandom), bv, bk, 4'($urandom), rv, 4'($urandom));
      checks++;
      if (obs_a_ready !== m_a_ready || obs_b_ready !== m_b_ready) begin
        errors++; $display("FAIL rnd_ready i=%0d got a=%b b=%b want a=%b b=%b", i, obs_a_ready, obs_b_ready, m_a_ready, m_b_ready);
      end
      checks++;
      if (db_valid !== m_db_valid || (m_db_valid && (db_key !== m_db_key || db_flag !== m_db_flag))) begin
        errors++; $display("FAIL rnd_issue i=%0d got v=%b key=%h flag=%h want v=%b key=%h flag=%h", i, db_valid, db_key, db_flag, m_db_valid, m_db_key, m_db_flag);
      end
      checks++;
      if (a_rsp_valid !== m_a_rsp_v || b_rsp_valid !== m_b_rsp_v ||
          (m_a_rsp_v && a_rsp_flag !== m_rsp_f) || (m_b_rsp_v && b_rsp_flag !== m_rsp_f)) begin
        errors++; $display("FAIL rnd_rsp i=%0d got a=%b/%h b=%b/%h want a=%b b=%b flag=%h", i, a_rsp_valid, a_rsp_flag, b_rsp_valid, b_rsp_flag, m_a_rsp_v, m_b_rsp_v, m_rsp_f);
      end
      checks++;
      if (err_timeout !== m_err_to || err_orphan !== m_err_or) begin
        errors++; $display("FAIL rnd_err i=%0d got to=%b or=%b want to=%b or=%b", i, err_timeout, err_orphan, m_err_to, m_err_or);
      end
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk);
    #1;
    test_single_a();
    test_alternate();
    test_back_to_back();
    test_orphan();
    test_timeout();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit reached at %0t with checks=%0d", $time, checks);
    $fatal(1, "time limit");
  end

endmodule
